// File: rtl/fir_ss_fifo_if.sv
// AXI4-Stream channel (tvalid/tdata/tlast/tready) shared by the FIFO's upstream and downstream sides.
// The master drives the payload and the slave answers with tready.
interface fir_ss_fifo_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   tvalid;
    logic [pDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic                   tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_ss_fifo.sv
// First-word fall-through AXI4-Stream FIFO feeding the FIR x-input port, with occupancy and frame count.
// Optional FIFO_STATS_EN adds peak-level tracking and a sticky overflow-pressure flag.
module fir_ss_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pADDR_W     = 4
) (
    input  logic               axis_clk,
    input  logic               axis_rst_n,
    input  logic               clr,
    fir_ss_fifo_if.slave       s_axis,
    fir_ss_fifo_if.master      m_axis,
    output logic [pADDR_W:0]   level,
    output logic               full,
    output logic               empty,
    output logic [pADDR_W:0]   pkt_cnt
`ifdef FIFO_STATS_EN
    ,
    input  logic               peak_clr,
    output logic [pADDR_W:0]   peak_level,
    output logic               drop_flag
`endif
);

    localparam logic [pADDR_W:0] LP_PTR_ONE = {{pADDR_W{1'b0}}, 1'b1};

    logic [pDATA_WIDTH:0] r_mem [pDEPTH];
    logic [pADDR_W:0]     r_wr_ptr;
    logic [pADDR_W:0]     r_rd_ptr;
    logic [pADDR_W:0]     r_pkt_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pkt_inc;
    logic                 w_pkt_dec;
    logic [pDATA_WIDTH:0] w_head;

    // Wrap bit distinguishes full from empty when the addresses coincide.
    assign w_full    = (r_wr_ptr[pADDR_W-1:0] == r_rd_ptr[pADDR_W-1:0]) &&
                       (r_wr_ptr[pADDR_W] != r_rd_ptr[pADDR_W]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push    = s_axis.tvalid & ~w_full;
    assign w_pop     = m_axis.tready & ~w_empty;
    assign w_head    = r_mem[r_rd_ptr[pADDR_W-1:0]];
    assign w_pkt_inc = w_push & s_axis.tlast;
    assign w_pkt_dec = w_pop & w_head[pDATA_WIDTH];

    assign s_axis.tready = ~w_full;
    assign level         = r_wr_ptr - r_rd_ptr;
    assign full          = w_full;
    assign empty         = w_empty;
    assign pkt_cnt       = r_pkt_cnt;

    // Head presentation: payload forced to zero while empty so stale storage never leaks out.
    always_comb begin
        m_axis.tvalid = ~w_empty;
        if (w_empty) begin
            m_axis.tdata = {pDATA_WIDTH{1'b0}};
            m_axis.tlast = 1'b0;
        end else begin
            m_axis.tdata = w_head[pDATA_WIDTH-1:0];
            m_axis.tlast = w_head[pDATA_WIDTH];
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge axis_clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr[pADDR_W-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // Pointer and frame-count state; clr flushes and discards any same-cycle push or pop.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_ptr  <= {(pADDR_W+1){1'b0}};
            r_rd_ptr  <= {(pADDR_W+1){1'b0}};
            r_pkt_cnt <= {(pADDR_W+1){1'b0}};
        end else if (clr) begin
            r_wr_ptr  <= {(pADDR_W+1){1'b0}};
            r_rd_ptr  <= {(pADDR_W+1){1'b0}};
            r_pkt_cnt <= {(pADDR_W+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + LP_PTR_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - LP_PTR_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

`ifdef FIFO_STATS_EN
    localparam logic [pADDR_W:0] LP_DEPTH    = (pADDR_W+1)'(pDEPTH);
    localparam logic [pADDR_W:0] LP_DEPTH_M1 = (pADDR_W+1)'(pDEPTH - 1);

    logic [pADDR_W:0] r_peak_level;
    logic [pADDR_W:0] r_stall_cnt;
    logic             r_drop_flag;
    logic             w_stall;

    assign w_stall    = s_axis.tvalid & w_full;
    assign peak_level = r_peak_level;
    assign drop_flag  = r_drop_flag;

    // High-water mark and sustained back-pressure detector.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_peak_level <= {(pADDR_W+1){1'b0}};
            r_stall_cnt  <= {(pADDR_W+1){1'b0}};
            r_drop_flag  <= 1'b0;
        end else if (peak_clr) begin
            r_peak_level <= level;
            r_stall_cnt  <= {(pADDR_W+1){1'b0}};
            r_drop_flag  <= 1'b0;
        end else begin
            if (level > r_peak_level) begin
                r_peak_level <= level;
            end
            if (w_stall) begin
                if (r_stall_cnt != LP_DEPTH) begin
                    r_stall_cnt <= r_stall_cnt + LP_PTR_ONE;
                end
                if (r_stall_cnt == LP_DEPTH_M1) begin
                    r_drop_flag <= 1'b1;
                end
            end else begin
                r_stall_cnt <= {(pADDR_W+1){1'b0}};
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_ss_fifo.sv
// Directed self-checking bench for fir_ss_fifo; stats checks are compiled in with FIFO_STATS_EN.
module tb_fir_ss_fifo;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic [4:0]  pkt_cnt;
`ifdef FIFO_STATS_EN
    logic        peak_clr;
    logic [4:0]  peak_level;
    logic        drop_flag;
`endif

    int n_vec = 0;
    int n_err = 0;

    fir_ss_fifo_if #(.pDATA_WIDTH(32)) s_if ();
    fir_ss_fifo_if #(.pDATA_WIDTH(32)) m_if ();

    fir_ss_fifo #(.pDATA_WIDTH(32), .pDEPTH(16), .pADDR_W(4)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .clr        (clr),
        .s_axis     (s_if.slave),
        .m_axis     (m_if.master),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .pkt_cnt    (pkt_cnt)
`ifdef FIFO_STATS_EN
        ,
        .peak_clr   (peak_clr),
        .peak_level (peak_level),
        .drop_flag  (drop_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (level !== 5'd0 || pkt_cnt !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: level=%0d pkt=%0d empty=%b full=%b, required 0 0 1 0", level, pkt_cnt, empty, full);
        end
        n_vec++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0 || m_if.tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_head: tvalid=%b tdata=%h tlast=%b, required 0 0 0", m_if.tvalid, m_if.tdata, m_if.tlast);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (s_if.tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tready: s_tready=%b, required 1", s_if.tready);
        end
    endtask

    task automatic test_basic_push();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        @(negedge clk);
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = vals[i];
            s_if.tlast  = (i == 2);
            @(negedge clk);
            if (i == 0) begin
                n_vec++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h11) begin
                    n_err++;
                    $display("FAIL fwft_latency: tvalid=%b tdata=%h, required 1 00000011", m_if.tvalid, m_if.tdata);
                end
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        n_vec++;
        if (level !== 5'd3 || pkt_cnt !== 5'd1 || m_if.tdata !== 32'h11) begin
            n_err++;
            $display("FAIL basic_level: level=%0d pkt=%0d tdata=%h, required 3 1 00000011", level, pkt_cnt, m_if.tdata);
        end
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (m_if.tdata !== vals[i] || m_if.tlast !== (i == 2)) begin
                n_err++;
                $display("FAIL basic_drain%0d: tdata=%h tlast=%b, required %h %b", i, m_if.tdata, m_if.tlast, vals[i], (i == 2));
            end
            @(negedge clk);
        end
        m_if.tready = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || pkt_cnt !== 5'd0 || m_if.tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty: empty=%b pkt=%0d tvalid=%b, required 1 0 0", empty, pkt_cnt, m_if.tvalid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h100 + 32'(i);
            @(negedge clk);
        end
        n_vec++;
        if (full !== 1'b1 || s_if.tready !== 1'b0 || level !== 5'd16) begin
            n_err++;
            $display("FAIL full_flag: full=%b s_tready=%b level=%0d, required 1 0 16", full, s_if.tready, level);
        end
        s_if.tdata = 32'hDEAD;
        repeat (20) @(negedge clk);
        n_vec++;
        if (level !== 5'd16 || m_if.tdata !== 32'h100) begin
            n_err++;
            $display("FAIL full_hold: level=%0d head=%h, required 16 00000100", level, m_if.tdata);
        end
`ifdef FIFO_STATS_EN
        n_vec++;
        if (peak_level !== 5'd16 || drop_flag !== 1'b1) begin
            n_err++;
            $display("FAIL stats_full: peak=%0d drop=%b, required 16 1", peak_level, drop_flag);
        end
`endif
        m_if.tready = 1'b1;
        @(negedge clk);
        m_if.tready = 1'b0;
        n_vec++;
        if (level !== 5'd15 || s_if.tready !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_no_push: level=%0d s_tready=%b, required 15 1", level, s_if.tready);
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        n_vec++;
        if (level !== 5'd16) begin
            n_err++;
            $display("FAIL full_retry: level=%0d, required 16", level);
        end
        m_if.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_d;
            exp_d = (i < 15) ? (32'h101 + 32'(i)) : 32'hDEAD;
            n_vec++;
            if (m_if.tdata !== exp_d) begin
                n_err++;
                $display("FAIL full_drain%0d: tdata=%h, required %h", i, m_if.tdata, exp_d);
            end
            @(negedge clk);
        end
        m_if.tready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL full_drain_empty: empty=%b, required 1", empty);
        end
`ifdef FIFO_STATS_EN
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        n_vec++;
        if (peak_level !== 5'd0 || drop_flag !== 1'b0) begin
            n_err++;
            $display("FAIL stats_clr: peak=%0d drop=%b, required 0 0", peak_level, drop_flag);
        end
`endif
    endtask

    task automatic test_back_to_back();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'd0;
        m_if.tready = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 40; i++) begin
            n_vec++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'(i - 1) || level !== 5'd1) begin
                n_err++;
                $display("FAIL stream%0d: tvalid=%b tdata=%0d level=%0d, required 1 %0d 1", i, m_if.tvalid, m_if.tdata, level, i - 1);
            end
            s_if.tdata = 32'(i);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        n_vec++;
        if (m_if.tdata !== 32'd39) begin
            n_err++;
            $display("FAIL stream_last: tdata=%0d, required 39", m_if.tdata);
        end
        @(negedge clk);
        m_if.tready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL stream_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_fir_pulse();
        int  wr_idx = 0;
        int  rd_idx = 0;
        int  cyc    = 0;
        bit  push;
        bit  pop;
        while (rd_idx < 64 && cyc < 2000) begin
            s_if.tvalid = (wr_idx < 64);
            s_if.tdata  = 32'(wr_idx);
            s_if.tlast  = (wr_idx == 63);
            m_if.tready = ((cyc % 11) == 0);
            #1;
            push = s_if.tvalid && s_if.tready;
            pop  = m_if.tvalid && m_if.tready;
            if (pop) begin
                n_vec++;
                if (m_if.tdata !== 32'(rd_idx) || m_if.tlast !== (rd_idx == 63)) begin
                    n_err++;
                    $display("FAIL fir_word%0d: tdata=%0d tlast=%b, required %0d %b", rd_idx, m_if.tdata, m_if.tlast, rd_idx, (rd_idx == 63));
                end
                if (rd_idx == 63) begin
                    n_vec++;
                    if (pkt_cnt !== 5'd1) begin
                        n_err++;
                        $display("FAIL fir_pkt_before: pkt=%0d, required 1", pkt_cnt);
                    end
                end
            end
            @(posedge clk);
            if (push) wr_idx++;
            if (pop)  rd_idx++;
            @(negedge clk);
            cyc++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        n_vec++;
        if (cyc >= 2000) begin
            n_err++;
            $display("FAIL fir_timeout: popped %0d words, required 64", rd_idx);
        end
        n_vec++;
        if (pkt_cnt !== 5'd0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL fir_pkt_after: pkt=%0d empty=%b, required 0 1", pkt_cnt, empty);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h50 + 32'(i);
            s_if.tlast  = (i == 1);
            @(negedge clk);
        end
        clr         = 1'b1;
        s_if.tdata  = 32'h77;
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b1;
        @(negedge clk);
        clr         = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        n_vec++;
        if (level !== 5'd0 || empty !== 1'b1 || pkt_cnt !== 5'd0 || m_if.tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_flush: level=%0d empty=%b pkt=%0d tvalid=%b, required 0 1 0 0", level, empty, pkt_cnt, m_if.tvalid);
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hA5;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        n_vec++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hA5 || level !== 5'd1) begin
            n_err++;
            $display("FAIL clr_after: tvalid=%b tdata=%h level=%0d, required 1 000000a5 1", m_if.tvalid, m_if.tdata, level);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'hC0 + 32'(i);
            s_if.tlast  = (i == 3);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        n_vec++;
        if (level !== 5'd7 || pkt_cnt !== 5'd1) begin
            n_err++;
            $display("FAIL async_pre: level=%0d pkt=%0d, required 7 1", level, pkt_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (level !== 5'd0 || empty !== 1'b1 || pkt_cnt !== 5'd0 || m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: level=%0d empty=%b pkt=%0d tvalid=%b tdata=%h, required 0 1 0 0 0", level, empty, pkt_cnt, m_if.tvalid, m_if.tdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (s_if.tready !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL async_release: s_tready=%b full=%b, required 1 0", s_if.tready, full);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'h0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
`ifdef FIFO_STATS_EN
        peak_clr    = 1'b0;
`endif
        test_reset();
        test_basic_push();
        test_full();
        test_back_to_back();
        test_fir_pulse();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
